// File: rtl/onehot_event_encoder.sv
// onehot_event_encoder
// Collects event pulses on N one-hot request lines into a pending register.
// Pending events are offered one at a time as a binary index over a
// valid/ready handshake, with round-robin fairness between the lines.
// A pending bit is cleared when its index is accepted.
// N must be a power of two, and IDX_W must equal $clog2(N), so that index
// arithmetic wraps naturally at N.

module onehot_event_encoder #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_in,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     pending,
    output logic             overflow
);

    // Two-state handshake FSM.
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] VALID = 1'b1;

    logic [0:0]       state_q,    state_d;
    logic [N-1:0]     pending_q,  pending_d;
    logic [IDX_W-1:0] out_idx_q,  out_idx_d;
    logic [IDX_W-1:0] rr_ptr_q,   rr_ptr_d;
    logic             overflow_q, overflow_d;

    logic             acc;
    logic [N-1:0]     clr;
    logic [N-1:0]     cand;

    // Round-robin pick: the first set bit of cand, searching upward from ptr
    // and wrapping past N-1 to 0. Returns 0 when cand is empty; callers only
    // use the result when cand is non-zero.
    function automatic logic [IDX_W-1:0] rr_select(
        input logic [N-1:0]     vec,
        input logic [IDX_W-1:0] ptr
    );
        logic [IDX_W-1:0] k;
        logic [IDX_W-1:0] pick;
        logic             found;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = ptr + IDX_W'(i);
            if (!found && vec[k]) begin
                pick  = k;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Handshake, clear mask, pending/overflow update and next-state selection.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the if/case can leave one unassigned and infer a latch.
        state_d    = state_q;
        out_idx_d  = out_idx_q;
        rr_ptr_d   = rr_ptr_q;
        cand       = '0;

        acc = (state_q == VALID) && out_ready;
        clr = acc ? ({{(N-1){1'b0}}, 1'b1} << out_idx_q) : '0;

        // A fresh request on the bit being cleared wins and re-arms it.
        pending_d  = (pending_q & ~clr) | req_in;
        // A request colliding with its own clear is a new event, not a loss.
        overflow_d = |(req_in & pending_q & ~clr);

        case (state_q)
            IDLE: begin
                if (pending_q != '0) begin
                    out_idx_d = rr_select(pending_q, rr_ptr_q);
                    state_d   = VALID;
                end
            end
            VALID: begin
                // Without out_ready the offer is frozen, even if a
                // higher-priority bit arrives meanwhile.
                if (out_ready) begin
                    rr_ptr_d = out_idx_q + 1'b1;
                    // Requests from this cycle are not yet eligible.
                    cand = pending_q & ~clr;
                    if (cand != '0) begin
                        out_idx_d = rr_select(cand, out_idx_q + 1'b1);
                    end else begin
                        // out_idx keeps its last value when going idle.
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            out_idx_q  <= '0;
            rr_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            out_idx_q  <= out_idx_d;
            rr_ptr_q   <= rr_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_idx   = out_idx_q;
    assign out_valid = (state_q == VALID);
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_onehot_event_encoder.sv
// tb_onehot_event_encoder
// Directed vectors with hand-computed expectations for onehot_event_encoder.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

module tb_onehot_event_encoder;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_in;
    logic [IDX_W-1:0] out_idx;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     pending;
    logic             overflow;

    int checks_total;
    int checks_passed;

    onehot_event_encoder #(.N(N), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle 1 unit before checking or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        req_in = '0;
        step();
        rst_n  = 1'b1;
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst_n     = 1'b0;
        req_in    = 8'hFF;
        out_ready = 1'b1;

        // 1 Reset held 3 cycles with all requests high.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_pending",  32'(pending),   32'h00);
            check("rst_valid",    32'(out_valid), 32'h0);
            check("rst_overflow", 32'(overflow),  32'h0);
            check("rst_idx",      32'(out_idx),   32'h0);
        end
        rst_n  = 1'b1;
        req_in = '0;

        // 2 Single event on line 2.
        req_in = 8'h04;
        step();
        check("single_pend", 32'(pending),   32'h04);
        check("single_v0",   32'(out_valid), 32'h0);
        req_in = '0;
        step();
        check("single_valid", 32'(out_valid), 32'h1);
        check("single_idx",   32'(out_idx),   32'h2);
        step();
        check("single_done_v", 32'(out_valid), 32'h0);
        check("single_done_p", 32'(pending),   32'h00);

        // 3 Round-robin burst from rr_ptr=0.
        do_reset();
        out_ready = 1'b1;
        req_in = 8'hFF;
        step();
        req_in = '0;
        step();
        for (int i = 0; i < 8; i++) begin
            check("burst0_valid", 32'(out_valid), 32'h1);
            check("burst0_idx",   32'(out_idx),   32'(i));
            step();
        end
        check("burst0_end_v", 32'(out_valid), 32'h0);
        check("burst0_end_p", 32'(pending),   32'h00);

        // Issue line 4 alone so rr_ptr becomes 5, then burst again.
        req_in = 8'h10;
        step();
        req_in = '0;
        step();
        check("rr5_idx", 32'(out_idx), 32'h4);
        step();
        check("rr5_idle", 32'(out_valid), 32'h0);
        req_in = 8'hFF;
        step();
        req_in = '0;
        step();
        for (int i = 0; i < 8; i++) begin
            check("burst5_valid", 32'(out_valid), 32'h1);
            check("burst5_idx",   32'((i + 5) % 8), 32'(out_idx) == 32'((i + 5) % 8) ? 32'((i + 5) % 8) : 32'(out_idx) ^ 32'h8);
            step();
        end
        check("burst5_end_v", 32'(out_valid), 32'h0);

        // 4 Backpressure: offer frozen at 0 while line 1 arrives.
        do_reset();
        out_ready = 1'b0;
        req_in = 8'h81;
        step();
        req_in = '0;
        step();
        check("bp_valid", 32'(out_valid), 32'h1);
        check("bp_idx",   32'(out_idx),   32'h0);
        req_in = 8'h02;
        for (int i = 0; i < 10; i++) begin
            step();
            req_in = '0;
            check("bp_hold_idx",   32'(out_idx),   32'h0);
            check("bp_hold_valid", 32'(out_valid), 32'h1);
        end
        check("bp_pending", 32'(pending), 32'h83);
        out_ready = 1'b1;
        step();
        check("bp_order1", 32'(out_idx), 32'h1);
        step();
        check("bp_order7", 32'(out_idx), 32'h7);
        step();
        check("bp_end_v", 32'(out_valid), 32'h0);

        // 5 Overflow on a pending, not-offered bit, then a collision.
        do_reset();
        out_ready = 1'b0;
        req_in = 8'h09;
        step();
        req_in = '0;
        step();
        check("ovf_offer0", 32'(out_idx), 32'h0);
        req_in = 8'h08;
        step();
        req_in = '0;
        check("ovf_pulse", 32'(overflow), 32'h1);
        step();
        check("ovf_clear", 32'(overflow), 32'h0);
        out_ready = 1'b1;
        step();
        check("col_offer3", 32'(out_idx),   32'h3);
        check("col_valid",  32'(out_valid), 32'h1);
        req_in = 8'h08;
        step();
        req_in = '0;
        check("col_overflow", 32'(overflow),  32'h0);
        check("col_pending",  32'(pending),   32'h08);
        check("col_idle",     32'(out_valid), 32'h0);
        step();
        check("col_reissue_v", 32'(out_valid), 32'h1);
        check("col_reissue_i", 32'(out_idx),   32'h3);
        step();
        check("col_done", 32'(out_valid), 32'h0);

        // 6 Reset in the middle of an offer (rr_ptr is 4 here).
        out_ready = 1'b0;
        req_in = 8'hF0;
        step();
        req_in = '0;
        step();
        check("mid_valid", 32'(out_valid), 32'h1);
        check("mid_idx",   32'(out_idx),   32'h4);
        check("mid_pend",  32'(pending),   32'hF0);
        out_ready = 1'b1;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_pend",  32'(pending),   32'h00);
        // Lines 2 and 5: rr_ptr=0 picks 2 first (rr_ptr=4 would pick 5).
        req_in = 8'h24;
        step();
        req_in = '0;
        step();
        check("mid_rr0_first",  32'(out_idx), 32'h2);
        step();
        check("mid_rr0_second", 32'(out_idx), 32'h5);
        step();
        check("mid_rr0_idle", 32'(out_valid), 32'h0);
        req_in = 8'h80;
        step();
        req_in = '0;
        step();
        check("fresh_valid", 32'(out_valid), 32'h1);
        check("fresh_idx",   32'(out_idx),   32'h7);
        step();
        check("fresh_done", 32'(out_valid), 32'h0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
